// File: rtl/gb_int_pkg.sv
// gb_int_pkg: definitions shared by the interrupt controller and the PC block.
//   - IRQ bit indices (bit position in IF/IE)
//   - Vector index encodings and a helper that maps an index to its address
//   - IF/IE register select codes
//   - Dispatch FSM state encoding
package gb_int_pkg;

  // IRQ bit positions in IF and IE
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  // Vector indices presented on int_vec
  localparam logic [2:0] VEC_VBLANK = 3'd0;
  localparam logic [2:0] VEC_STAT   = 3'd1;
  localparam logic [2:0] VEC_TIMER  = 3'd2;
  localparam logic [2:0] VEC_SERIAL = 3'd3;
  localparam logic [2:0] VEC_JOYPAD = 3'd4;

  // Register select codes on reg_sel
  localparam logic REG_SEL_IF = 1'b0;  // FF0F
  localparam logic REG_SEL_IE = 1'b1;  // FFFF

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } int_state_e;

  // Vector index 0..4 -> 0x40, 0x48, 0x50, 0x58, 0x60
  function automatic logic [7:0] vec_to_addr(input logic [2:0] vec);
    return 8'h40 + {2'b00, vec, 3'b000};
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-set-bit priority encoder.
// Ports:
//   mask  [WIDTH-1:0] in  - pending request mask
//   index [2:0]       out - index of the lowest set bit (0 when none set)
//   valid             out - high when any mask bit is set
module int_prio_enc #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] mask,
  output logic [2:0]       index,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IF/IE registers, IME, and the two-state dispatch sequencer.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   irq_in[NUM_IRQ-1:0]   - one-cycle request pulses (bit 0 VBlank .. bit 4 Joypad)
//   reg_wr, reg_sel       - register write strobe; select 0 = IF, 1 = IE
//   wr_data[7:0]          - register write data
//   rd_data[7:0]          - combinational read of the selected register
//   instr_boundary        - CPU is about to fetch an opcode
//   ei, di, reti          - instruction strobes
//   int_ack               - CPU has loaded PC from int_vec
//   int_pending           - (IF & IE) nonzero regardless of IME (HALT wake)
//   int_take, int_vec     - dispatch request and its vector index
//   fsm_state             - current dispatch state (observability)
// Build option: INT_CTRL_EI_DELAY_EN -- ei arms an EI-pending flag which sets
//   IME at the next instr_boundary, so the instruction after EI runs before
//   any dispatch. Without it, ei sets IME the next cycle.
//
// Handshake: int_take rises the cycle after an accepted dispatch and holds,
// with int_vec frozen, until int_ack is sampled high; int_take drops the
// following cycle. int_ack outside a dispatch is ignored.
module interrupt_ctrl
  import gb_int_pkg::*;
#(
  parameter int   NUM_IRQ      = 5,
  parameter logic IF_UNUSED_RD = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               reg_wr,
  input  logic               reg_sel,
  input  logic [7:0]         wr_data,
  output logic [7:0]         rd_data,
  input  logic               instr_boundary,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               int_ack,
  output logic               int_pending,
  output logic               int_take,
  output logic [2:0]         int_vec,
  output int_state_e         fsm_state
);

  int_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [2:0]         vec_q, vec_d;
  logic               ime_q, ime_d;
`ifdef INT_CTRL_EI_DELAY_EN
  logic               ei_pend_q, ei_pend_d;
`endif

  logic [NUM_IRQ-1:0] pend_mask;
  logic [2:0]         prio_idx;
  logic               prio_valid;

  assign pend_mask = if_q & ie_q[NUM_IRQ-1:0];

  int_prio_enc #(.WIDTH(NUM_IRQ)) u_prio (
    .mask  (pend_mask),
    .index (prio_idx),
    .valid (prio_valid)
  );

  always_comb begin
    state_d = state_q;
    if_d    = if_q;
    ie_d    = ie_q;
    vec_d   = vec_q;
    ime_d   = ime_q;
`ifdef INT_CTRL_EI_DELAY_EN
    ei_pend_d = ei_pend_q;
`endif

    // A request pulse is OR-ed after the write so it is never lost.
    if (reg_wr && reg_sel == REG_SEL_IF) if_d = wr_data[NUM_IRQ-1:0];
    if_d = if_d | irq_in;
    if (reg_wr && reg_sel == REG_SEL_IE) ie_d = wr_data;

    // IME updates, lowest to highest precedence: EI, RETI, DI, dispatch.
`ifdef INT_CTRL_EI_DELAY_EN
    if (instr_boundary && ei_pend_q) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (ei) ei_pend_d = 1'b1;
    if (reti) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (di) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end
`else
    if (ei || reti) ime_d = 1'b1;
    if (di) ime_d = 1'b0;
`endif

    // Dispatch decisions use the registered IME, so a boundary that sets
    // IME never dispatches in the same cycle.
    case (state_q)
      ST_IDLE: begin
        if (instr_boundary && ime_q && prio_valid) begin
          state_d = ST_DISPATCH;
          vec_d   = prio_idx;
          ime_d   = 1'b0;
        end
      end
      ST_DISPATCH: begin
        if (int_ack) begin
          // Acknowledge clear beats a same-cycle request on that bit.
          if_d    = if_d & ~(NUM_IRQ'(1) << vec_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      if_q    <= '0;
      ie_q    <= '0;
      vec_q   <= '0;
      ime_q   <= 1'b0;
`ifdef INT_CTRL_EI_DELAY_EN
      ei_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if_q    <= if_d;
      ie_q    <= ie_d;
      vec_q   <= vec_d;
      ime_q   <= ime_d;
`ifdef INT_CTRL_EI_DELAY_EN
      ei_pend_q <= ei_pend_d;
`endif
    end
  end

  assign rd_data     = (reg_sel == REG_SEL_IF) ? {{(8 - NUM_IRQ){IF_UNUSED_RD}}, if_q} : ie_q;
  assign int_pending = prio_valid;
  assign int_take    = (state_q == ST_DISPATCH);
  assign int_vec     = vec_q;
  assign fsm_state   = state_q;

endmodule
